// File: rtl/xadc_drp_arbiter.sv
// Shares the XADC DRP port between the eoc-triggered sampler and a host register port.
// One DRP transaction at a time, round-robin on ties, drdy timeout aborts with an error.
module xadc_drp_arbiter #(
   parameter logic [6:0]  SAMPLE_ADDR = 7'h12,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        eoc_in,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [6:0]  host_addr,
   input  logic [15:0] host_wdata,
   output logic        host_ack,
   output logic [15:0] host_rdata,
   output logic        host_err,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [6:0]  drp_daddr,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic        sample_valid,
   output logic [11:0] sample_data,
   output logic        overrun
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic {OWN_SAMPLE = 1'b0, OWN_HOST = 1'b1} owner_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      state_q;
   owner_t      owner_q, last_grant_q;
   logic        we_q;
   logic [7:0]  cnt_q;
   logic        sample_pend_q, sample_pend_d;
   logic        overrun_q, overrun_d;
   logic        den_q, dwe_q;
   logic [6:0]  daddr_q;
   logic [15:0] di_q;
   logic        host_ack_q, host_err_q;
   logic [15:0] host_rdata_q;
   logic        sample_valid_q;
   logic [11:0] sample_data_q;
   logic        samp_req, grant_sample, grant_host;

   // A live eoc counts as a sample request straight away, so a coincident host
   // request still loses the first tie to the sampler.
   always_comb begin
      samp_req     = sample_pend_q | eoc_in;
      grant_sample = 1'b0;
      grant_host   = 1'b0;
      if (state_q == S_IDLE) begin
         if (samp_req && host_req) begin
            grant_sample = (last_grant_q == OWN_HOST);
            grant_host   = (last_grant_q == OWN_SAMPLE);
         end else begin
            grant_sample = samp_req;
            grant_host   = host_req;
         end
      end
      sample_pend_d = sample_pend_q;
      if (grant_sample)
         sample_pend_d = sample_pend_q & eoc_in;  // eoc that was itself the request is consumed
      else if (eoc_in)
         sample_pend_d = 1'b1;
      overrun_d = eoc_in & sample_pend_q & ~grant_sample;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         owner_q        <= OWN_SAMPLE;
         last_grant_q   <= OWN_HOST;
         we_q           <= 1'b0;
         cnt_q          <= '0;
         sample_pend_q  <= 1'b0;
         overrun_q      <= 1'b0;
         den_q          <= 1'b0;
         dwe_q          <= 1'b0;
         daddr_q        <= '0;
         di_q           <= '0;
         host_ack_q     <= 1'b0;
         host_err_q     <= 1'b0;
         host_rdata_q   <= '0;
         sample_valid_q <= 1'b0;
         sample_data_q  <= '0;
      end else begin
         sample_pend_q <= sample_pend_d;
         overrun_q     <= overrun_d;
         case (state_q)
            S_IDLE: begin
               if (grant_sample || grant_host) begin
                  owner_q <= grant_host ? OWN_HOST : OWN_SAMPLE;
                  we_q    <= grant_host & host_we;
                  dwe_q   <= grant_host & host_we;
                  daddr_q <= grant_host ? host_addr : SAMPLE_ADDR;
                  di_q    <= grant_host ? host_wdata : 16'h0000;
                  den_q   <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               den_q   <= 1'b0;
               dwe_q   <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (drp_drdy) begin
                  state_q <= S_DONE;
                  if (owner_q == OWN_SAMPLE) begin
                     sample_data_q  <= drp_do[15:4];
                     sample_valid_q <= 1'b1;
                  end else begin
                     host_ack_q <= 1'b1;
                     host_err_q <= 1'b0;
                     if (!we_q) host_rdata_q <= drp_do;
                  end
               end else if (cnt_q == TO_LAST) begin
                  // Timed-out sample is dropped silently; the host gets an error ack.
                  state_q <= S_DONE;
                  if (owner_q == OWN_HOST) begin
                     host_ack_q <= 1'b1;
                     host_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DONE: begin
               sample_valid_q <= 1'b0;
               host_ack_q     <= 1'b0;
               host_err_q     <= 1'b0;
               last_grant_q   <= owner_q;
               state_q        <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign host_ack     = host_ack_q;
   assign host_rdata   = host_rdata_q;
   assign host_err     = host_err_q;
   assign drp_den      = den_q;
   assign drp_dwe      = dwe_q;
   assign drp_daddr    = daddr_q;
   assign drp_di       = di_q;
   assign sample_valid = sample_valid_q;
   assign sample_data  = sample_data_q;
   assign overrun      = overrun_q;

endmodule
